// File: rtl/count_monitor_if.sv
// Interface bundling the counter input, threshold/control pulses, snapshot
// handshake and status outputs of count_monitor.
interface count_monitor_if #(
  parameter int CNT_W = 8,
  parameter int EXT_W = 8
) ();
  localparam int XW = CNT_W + EXT_W;

  logic [CNT_W-1:0] cnt_in;
  logic             arm;
  logic             clr;
  logic [XW-1:0]    thresh;
  logic             snap_req;
  logic             snap_ready;
  logic             snap_valid;
  logic [XW-1:0]    snap_data;
  logic [XW-1:0]    ext_cnt;
  logic             hit;
  logic             wrap_ovf;

  // master drives the counter and control side; slave is the monitor itself
  modport master (
    output cnt_in, arm, clr, thresh, snap_req, snap_ready,
    input  snap_valid, snap_data, ext_cnt, hit, wrap_ovf
  );

  modport slave (
    input  cnt_in, arm, clr, thresh, snap_req, snap_ready,
    output snap_valid, snap_data, ext_cnt, hit, wrap_ovf
  );
endinterface

// File: rtl/count_monitor.sv
// Extends an 8-bit free-running counter with a saturating wrap count, runs a
// sticky threshold comparator and offers a valid/ready snapshot of the count.
module count_monitor #(
  parameter int CNT_W = 8,
  parameter int EXT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  count_monitor_if.slave   bus
);
  localparam int XW = CNT_W + EXT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } state_e;

  logic [CNT_W-1:0] cnt_prev_q, cnt_prev_d;
  logic [EXT_W-1:0] wraps_q, wraps_d;
  logic             wrap_ovf_q, wrap_ovf_d;
  logic [XW-1:0]    ext_cnt_q, ext_cnt_d;
  state_e           state_q, state_d;
  logic             snap_valid_q, snap_valid_d;
  logic [XW-1:0]    snap_data_q, snap_data_d;
  logic             wrap;

  // Wrap tracking; clr takes priority over a wrap seen in the same cycle.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    cnt_prev_d = bus.cnt_in;
    wrap       = bus.cnt_in < cnt_prev_q;
    wraps_d    = wraps_q;
    wrap_ovf_d = wrap_ovf_q;
    if (bus.clr) begin
      wraps_d    = '0;
      wrap_ovf_d = 1'b0;
    end else if (wrap) begin
      if (&wraps_q) wrap_ovf_d = 1'b1;
      else          wraps_d    = wraps_q + EXT_W'(1);
    end
    ext_cnt_d = {wraps_d, bus.cnt_in};
  end

  // Next-state logic; the comparison uses the registered extended count.
  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (bus.arm) state_d = ARMED;
        ARMED:   if (ext_cnt_q >= bus.thresh) state_d = HIT;
        HIT:     state_d = HIT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Snapshot: capture only when the holding register is empty, so a request
  // in the accept cycle is dropped rather than chained back-to-back.
  always_comb begin
    snap_valid_d = snap_valid_q;
    snap_data_d  = snap_data_q;
    if (snap_valid_q) begin
      if (bus.snap_ready) snap_valid_d = 1'b0;
    end else if (bus.snap_req) begin
      snap_valid_d = 1'b1;
      snap_data_d  = ext_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // from pre-edge values regardless of process ordering.
    if (!reset) begin
      cnt_prev_q   <= '0;
      wraps_q      <= '0;
      wrap_ovf_q   <= 1'b0;
      ext_cnt_q    <= '0;
      state_q      <= IDLE;
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
    end else begin
      cnt_prev_q   <= cnt_prev_d;
      wraps_q      <= wraps_d;
      wrap_ovf_q   <= wrap_ovf_d;
      ext_cnt_q    <= ext_cnt_d;
      state_q      <= state_d;
      snap_valid_q <= snap_valid_d;
      snap_data_q  <= snap_data_d;
    end
  end

  always_comb begin
    bus.hit        = (state_q == HIT);
    bus.wrap_ovf   = wrap_ovf_q;
    bus.ext_cnt    = ext_cnt_q;
    bus.snap_valid = snap_valid_q;
    bus.snap_data  = snap_data_q;
  end
endmodule
